// File: rtl/mem_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : configure (package)
//  Description : Shared router configuration: slave count, timeout default,
//                address map (inclusive base, exclusive top) and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package configure;

  localparam int nslv           = 3;
  localparam int router_timeout = 256;

  // Region table: bram, print, clint
  localparam logic [31:0] slv_base_addr [nslv] = '{
    32'h0000_0000, 32'h0100_0000, 32'h0200_0000
  };
  localparam logic [31:0] slv_top_addr [nslv] = '{
    32'h0010_0000, 32'h0100_0004, 32'h0200_C000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } router_state_t;

  // Width of a slave index; a single-slave router still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_router_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : addr_decode
//  Description : Combinational region match with lowest-index priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_decode
  import configure::*;
#(
  parameter int          NSLV       = nslv,
  parameter int          SELW       = sel_width(NSLV),
  parameter logic [31:0] BASE [NSLV] = slv_base_addr,
  parameter logic [31:0] TOP  [NSLV] = slv_top_addr
) (
  input  logic [31:0]     addr,
  output logic            hit,
  output logic [SELW-1:0] sel
);

  // Walk from the highest index down so the lowest matching region wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr >= BASE[i]) && (addr < TOP[i])) begin
        hit = 1'b1;
        sel = SELW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_router.sv
`default_nettype none
// ============================================================================
//  Module      : mem_router
//  Description : Routes the core memory port to one of NSLV slaves through a
//                region table; unmapped or stalled accesses return an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_router
  import configure::*;
#(
  parameter int          NSLV        = nslv,
  parameter int          TIMEOUT     = router_timeout,
  parameter logic [31:0] BASE [NSLV] = slv_base_addr,
  parameter logic [31:0] TOP  [NSLV] = slv_top_addr
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               m_valid,
  input  logic               m_instr,
  input  logic [31:0]        m_addr,
  input  logic [31:0]        m_wdata,
  input  logic [3:0]         m_wstrb,
  output logic               m_ready,
  output logic [31:0]        m_rdata,
  output logic               m_error,
  output logic [NSLV-1:0]    s_valid,
  output logic               s_instr,
  output logic [31:0]        s_addr,
  output logic [31:0]        s_wdata,
  output logic [3:0]         s_wstrb,
  input  logic [NSLV-1:0]    s_ready,
  input  logic [NSLV*32-1:0] s_rdata
);

  localparam int          SELW        = sel_width(NSLV);
  localparam bit          C_TO_EN     = (TIMEOUT != 0);
  localparam logic [15:0] C_TO_LAST   = 16'(TIMEOUT - 1);

  router_state_t   r_state, w_state_nxt;
  logic [SELW-1:0] r_sel, w_sel_nxt;
  logic [15:0]     r_cnt, w_cnt_nxt;
  logic            r_m_ready, w_m_ready_nxt;
  logic            r_m_error, w_m_error_nxt;
  logic [31:0]     r_m_rdata, w_m_rdata_nxt;
  logic [NSLV-1:0] r_s_valid, w_s_valid_nxt;
  logic            r_s_instr, w_s_instr_nxt;
  logic [31:0]     r_s_addr, w_s_addr_nxt;
  logic [31:0]     r_s_wdata, w_s_wdata_nxt;
  logic [3:0]      r_s_wstrb, w_s_wstrb_nxt;

  logic            w_hit;
  logic [SELW-1:0] w_sel;

  addr_decode #(
    .NSLV (NSLV),
    .SELW (SELW),
    .BASE (BASE),
    .TOP  (TOP)
  ) u_addr_decode (
    .addr (m_addr),
    .hit  (w_hit),
    .sel  (w_sel)
  );

  // Next-state and next-output decision; every output is registered below.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_cnt_nxt     = r_cnt;
    w_m_ready_nxt = 1'b0;
    w_m_error_nxt = r_m_error;
    w_m_rdata_nxt = r_m_rdata;
    w_s_valid_nxt = r_s_valid;
    w_s_instr_nxt = r_s_instr;
    w_s_addr_nxt  = r_s_addr;
    w_s_wdata_nxt = r_s_wdata;
    w_s_wstrb_nxt = r_s_wstrb;
    case (r_state)
      IDLE: begin
        if (m_valid) begin
          if (w_hit) begin
            w_sel_nxt     = w_sel;
            w_cnt_nxt     = '0;
            w_s_valid_nxt = NSLV'(1) << w_sel;
            w_s_instr_nxt = m_instr;
            w_s_addr_nxt  = m_addr;
            w_s_wdata_nxt = m_wdata;
            w_s_wstrb_nxt = m_wstrb;
            w_state_nxt   = BUSY;
          end else begin
            // Unmapped: answer directly, no slave is touched.
            w_m_error_nxt = 1'b1;
            w_m_rdata_nxt = '0;
            w_m_ready_nxt = 1'b1;
            w_state_nxt   = RESP;
          end
        end
      end
      BUSY: begin
        if (s_ready[r_sel]) begin
          w_m_rdata_nxt = s_rdata[32*r_sel +: 32];
          w_m_error_nxt = 1'b0;
          w_s_valid_nxt = '0;
          w_m_ready_nxt = 1'b1;
          w_state_nxt   = RESP;
        end else if (C_TO_EN && (r_cnt == C_TO_LAST)) begin
          // Stalled slave: abandon it so the core is never hung.
          w_m_rdata_nxt = '0;
          w_m_error_nxt = 1'b1;
          w_s_valid_nxt = '0;
          w_m_ready_nxt = 1'b1;
          w_state_nxt   = RESP;
        end else if (r_cnt != 16'hFFFF) begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_m_ready <= 1'b0;
      r_m_error <= 1'b0;
      r_m_rdata <= '0;
      r_s_valid <= '0;
      r_s_instr <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wstrb <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_cnt     <= w_cnt_nxt;
      r_m_ready <= w_m_ready_nxt;
      r_m_error <= w_m_error_nxt;
      r_m_rdata <= w_m_rdata_nxt;
      r_s_valid <= w_s_valid_nxt;
      r_s_instr <= w_s_instr_nxt;
      r_s_addr  <= w_s_addr_nxt;
      r_s_wdata <= w_s_wdata_nxt;
      r_s_wstrb <= w_s_wstrb_nxt;
    end
  end

  assign m_ready = r_m_ready;
  assign m_error = r_m_error;
  assign m_rdata = r_m_rdata;
  assign s_valid = r_s_valid;
  assign s_instr = r_s_instr;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign s_wstrb = r_s_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_router
//  Description : Self-checking bench for mem_router with a transaction-level
//                expected-trace model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_router;

  localparam int NS = 3;
  localparam int TO = 8;

  // Address map as written in the requirements, kept independent of the RTL.
  localparam logic [31:0] M_BASE [NS] = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000};
  localparam logic [31:0] M_TOP  [NS] = '{32'h0010_0000, 32'h0100_0004, 32'h0200_C000};

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           m_valid = 1'b0;
  logic           m_instr = 1'b0;
  logic [31:0]    m_addr = '0;
  logic [31:0]    m_wdata = '0;
  logic [3:0]     m_wstrb = '0;
  logic           m_ready;
  logic [31:0]    m_rdata;
  logic           m_error;
  logic [NS-1:0]  s_valid;
  logic           s_instr;
  logic [31:0]    s_addr;
  logic [31:0]    s_wdata;
  logic [3:0]     s_wstrb;
  logic [NS-1:0]  s_ready = '0;
  logic [NS*32-1:0] s_rdata = '0;

  mem_router #(.NSLV(NS), .TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset   (reset),
    .m_valid (m_valid),
    .m_instr (m_instr),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .m_error (m_error),
    .s_valid (s_valid),
    .s_instr (s_instr),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_ready (s_ready),
    .s_rdata (s_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;
  int last_lat = -1;
  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;
  bit          chk_en     = 1'b0;

  typedef struct {
    logic [NS-1:0] sv;
    bit            mr;
    bit            me;
    logic [31:0]   md;
    logic [31:0]   sa;
    logic [31:0]   sw;
    logic [3:0]    ss;
    bit            si;
  } exp_t;

  exp_t expq[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
  endtask

  // Region rule: lowest index with base <= addr < top, or -1 when unmapped.
  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (a >= M_BASE[i] && a < M_TOP[i]) return i;
    return -1;
  endfunction

  // Per-cycle compare against the expected trace; no pending trace means idle.
  always @(negedge clock) begin
    exp_t e;
    if (chk_en && reset) begin
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("s_valid", 32'(s_valid), 32'(e.sv));
        chk("m_ready", 32'(m_ready), 32'(e.mr));
        if (e.mr) begin
          chk("m_error", 32'(m_error), 32'(e.me));
          chk("m_rdata", m_rdata, e.md);
        end
        if (e.sv != '0) begin
          chk("s_addr", s_addr, e.sa);
          chk("s_wdata", s_wdata, e.sw);
          chk("s_wstrb", 32'(s_wstrb), 32'(e.ss));
          chk("s_instr", 32'(s_instr), 32'(e.si));
        end
      end else begin
        chk("idle_s_valid", 32'(s_valid), 32'h0);
        chk("idle_m_ready", 32'(m_ready), 32'h0);
      end
      if (m_ready === 1'b1) begin
        last_lat   = cyc - t0;
        last_rdata = m_rdata;
        last_err   = m_error;
      end
    end
  end

  // One master transaction; called just after a rising edge with the DUT idle.
  // The selected slave answers in BUSY cycle 'wt' (0 = first); other slaves
  // hold s_ready high throughout as noise that must be ignored.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input bit ins, input int wt, input logic [31:0] rd);
    int sel, n;
    exp_t e;
    logic [NS-1:0] oh;
    sel = model_sel(a);
    oh  = (sel < 0) ? '0 : NS'(1 << sel);
    n   = (sel < 0) ? 0 : ((wt < TO) ? wt + 1 : TO);
    t0  = cyc;
    e = '{sv: '0, mr: 1'b0, me: 1'b0, md: '0, sa: '0, sw: '0, ss: '0, si: 1'b0};
    expq.push_back(e);
    for (int c = 1; c <= n; c++) begin
      e.sv = oh; e.sa = a; e.sw = wd; e.ss = ws; e.si = ins;
      expq.push_back(e);
    end
    e.sv = '0;
    e.mr = 1'b1;
    e.me = (sel < 0) || (wt >= TO);
    e.md = e.me ? 32'h0 : rd;
    expq.push_back(e);

    for (int i = 0; i < NS; i++)
      s_rdata[i*32 +: 32] = (i == sel) ? rd : (32'hBAD0_0000 | 32'(i));
    m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws; m_instr = ins;
    s_ready = '0;
    for (int c = 1; c <= n + 1; c++) begin
      @(posedge clock); #1;
      if (c <= n) s_ready = ~oh | (((c - 1) == wt) ? oh : '0);
      else        s_ready = '0;
    end
    @(posedge clock); #1;
    m_valid = 1'b0;
    s_ready = '0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    // Reset values while reset is held low
    #12;
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_m_ready", 32'(m_ready), 32'h0);
    chk("rst_m_error", 32'(m_error), 32'h0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_s_addr",  s_addr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_s_wstrb", 32'(s_wstrb), 32'h0);
    chk("rst_s_instr", 32'(s_instr), 32'h0);
    @(posedge clock); #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Read served in the first BUSY cycle
    txn(32'h0000_0100, 32'h0, 4'h0, 1'b0, 0, 32'hDEAD_BEEF);
    chk("read_latency", 32'(last_lat), 32'd2);
    chk("read_rdata", last_rdata, 32'hDEAD_BEEF);
    idle(2);

    // Write to print with three wait cycles
    txn(32'h0100_0000, 32'h0000_0041, 4'hF, 1'b0, 3, 32'h0);
    chk("write_latency", 32'(last_lat), 32'd5);
    chk("write_error", 32'(last_err), 32'h0);
    idle(1);

    // Unmapped: BRAM top (exclusive) and a hole in the map
    txn(32'h0010_0000, 32'h0, 4'h0, 1'b0, 0, 32'h1111_1111);
    chk("unmap_top_latency", 32'(last_lat), 32'd1);
    chk("unmap_top_error", 32'(last_err), 32'h1);
    txn(32'h0300_0000, 32'h0, 4'h0, 1'b1, 0, 32'h2222_2222);
    chk("unmap_hole_rdata", last_rdata, 32'h0);
    idle(1);

    // Timeout on CLINT, then a normal access right behind it
    txn(32'h0200_0000, 32'h5, 4'h3, 1'b0, 1000, 32'h3333_3333);
    chk("timeout_latency", 32'(last_lat), 32'd9);
    chk("timeout_error", 32'(last_err), 32'h1);
    txn(32'h0000_0004, 32'h0, 4'h0, 1'b1, 1, 32'hA5A5_5A5A);
    chk("after_timeout_rdata", last_rdata, 32'hA5A5_5A5A);

    // Back-to-back requests across slaves, last byte of regions
    txn(32'h0200_BFFC, 32'h0, 4'h0, 1'b0, 1, 32'h00C0_FFEE);
    txn(32'h0100_0003, 32'h0000_00AB, 4'h8, 1'b0, 0, 32'h0);
    txn(32'h000F_FFFC, 32'h1234_5678, 4'h5, 1'b0, 2, 32'h7777_0000);
    chk("b2b_last_latency", 32'(last_lat), 32'd4);
    idle(2);

    // Reset pulled while BUSY
    chk_en = 1'b0;
    expq.delete();
    m_valid = 1'b1; m_addr = 32'h0000_0040; m_wdata = 32'hFFFF_0000; m_wstrb = 4'hF;
    @(posedge clock); #1;
    m_valid = 1'b0;
    chk("busy_s_valid", 32'(s_valid), 32'h1);
    chk("busy_s_addr", s_addr, 32'h0000_0040);
    #2 reset = 1'b0;
    #1;
    chk("arst_s_valid", 32'(s_valid), 32'h0);
    chk("arst_s_addr", s_addr, 32'h0);
    chk("arst_s_wdata", s_wdata, 32'h0);
    chk("arst_m_ready", 32'(m_ready), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk_en = 1'b1;
    txn(32'h0000_0000, 32'h0, 4'h0, 1'b0, 0, 32'h1234_5678);
    chk("post_rst_latency", 32'(last_lat), 32'd2);
    chk("post_rst_rdata", last_rdata, 32'h1234_5678);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_router.md
# mem_router

Parametrised address-map router between the core's single memory master port and NSLV slave ports (BRAM, print, CLINT and future peripherals). It replaces fixed per-peripheral decoding with a region table. Each master request is routed to the lowest-indexed matching slave, and the response is returned to the master. Unmapped accesses and stalled slaves produce an error response instead of hanging the core.

## Interface
Parameters:
- NSLV, 3: number of slave ports and region-table entries (1..8)
- TIMEOUT, 256: maximum BUSY cycles before a forced error response; 0 disables the timeout
- BASE, package map: array [NSLV] of 32-bit inclusive region bases
- TOP, package map: array [NSLV] of 32-bit exclusive region tops

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m_valid  in  1  master request valid, held until m_ready
- m_instr  in  1  instruction fetch flag, passed through to the slave
- m_addr  in  32  byte address
- m_wdata  in  32  write data
- m_wstrb  in  4  byte write strobes; 0 means read
- m_ready  out  1  single-cycle response pulse
- m_rdata  out  32  read data, valid while m_ready=1
- m_error  out  1  error flag, valid while m_ready=1
- s_valid  out  NSLV  one-hot slave request
- s_instr  out  1  registered copy of m_instr
- s_addr  out  32  registered address, shared by all slaves
- s_wdata  out  32  registered write data
- s_wstrb  out  4  registered write strobes
- s_ready  in  NSLV  slave response ready, one bit per slave
- s_rdata  in  NSLV*32  slave read data, slave i at bits [32i+31:32i]

## Operation
- States are IDLE, BUSY and RESP.
- IDLE with m_valid=1:
  - Decode: hit[i] = (m_addr >= BASE[i]) && (m_addr < TOP[i]).
  - Select the lowest i with hit[i]=1.
  - On a hit, register addr, wdata, wstrb and instr, set s_valid[sel]=1, clear the timeout counter, and go to BUSY.
  - On no hit, go to RESP with m_error=1 and m_rdata=0. No slave sees the access.
- BUSY:
  - If s_ready[sel]=1: register s_rdata[sel] into m_rdata, set m_error=0, clear s_valid, go to RESP.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without s_ready[sel]: clear s_valid, set m_error=1 and m_rdata=0, go to RESP.
  - The counter otherwise increments; it is 16 bits wide and saturates.
  - s_ready bits of non-selected slaves are ignored.
- RESP: m_ready=1 for exactly one cycle, then return to IDLE.
- Master contract: m_valid drops, or presents a new request, in the cycle after the m_ready pulse. A new request presented in that cycle is accepted the following IDLE cycle.
- Only one transaction is outstanding at a time. Master inputs are ignored outside IDLE.
- Write data and strobes are forwarded unmodified. Slave write errors are not reported.

## Timing
- Reset values: state IDLE, s_valid=0, m_ready=0, m_error=0, m_rdata=0, s_addr/s_wdata/s_wstrb/s_instr=0, counter=0.
- Mapped access, slave ready in its first BUSY cycle: m_valid at cycle 0, s_valid in cycle 1, m_ready in cycle 2.
- Every extra slave wait cycle adds one cycle of latency.
- Unmapped access: m_valid at cycle 0, m_ready with m_error=1 in cycle 1.
- Timeout: s_valid is high for exactly TIMEOUT cycles, and m_ready follows in the next cycle.
- Every output is registered. There is no combinational path from s_ready to m_ready, or from m_addr to s_valid.
- Reset asserted mid-transaction returns the block to reset values immediately. Any pending slave access is abandoned.
- An address equal to TOP[i] does not hit region i.
- Overlapping regions resolve to the lowest index.

## Structure
- The shared package `configure` holds:
  - `nslv`
  - `router_timeout`
  - the address-map arrays `slv_base_addr[nslv]` and `slv_top_addr[nslv]`, with defaults:
    - bram 0x0–0x100000
    - print 0x1000000–0x1000004
    - clint 0x2000000–0x200C000
  - typedef `router_state_t` (IDLE, BUSY, RESP)
- One sub-module, `addr_decode`: combinational region match plus priority encoder, producing `hit` and a `sel` index of clog2(NSLV) bits.

## Test plan
- Read 0x00000100, slave 0 returns 0xDEADBEEF in its first BUSY cycle → m_ready at cycle 2, m_rdata=0xDEADBEEF, m_error=0, only s_valid[0] pulsed.
- Write 0x01000000, wstrb=0xF, wdata=0x41, slave 1 waits 3 cycles → s_addr/s_wdata correct, m_ready at cycle 5, m_error=0.
- Read 0x00100000 (the BRAM top) and 0x3000000 → m_ready in cycle 1, m_error=1, m_rdata=0, s_valid never set.
- TIMEOUT=8, slave 2 (0x2000000) never ready → s_valid[2] high for 8 cycles, then m_ready with m_error=1; a following request to slave 0 completes normally.
- Back-to-back: new request presented in the cycle after m_ready → accepted, correct routing, no duplicate access.
- Reset pulled low while in BUSY → all outputs return to 0 asynchronously; after release, a read of 0x0 completes in 2 cycles.
